// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between NUM_REQ requesters.
// Each transaction: accept (IDLE) -> drive ALU for one cycle (EXEC) -> return result (RESP).
package ablomm_cpu;
    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SHL = 4'h5,
        ALU_SHR = 4'h6,
        ALU_ASR = 4'h7
    } alu_op_e;
endpackage

module alu_arbiter
    import ablomm_cpu::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic    [NUM_REQ-1:0]         req_valid,
    output logic    [NUM_REQ-1:0]         req_ready,
    input  alu_op_e [NUM_REQ-1:0]         req_op,
    input  logic    [NUM_REQ-1:0][31:0]   req_a,
    input  logic    [NUM_REQ-1:0][31:0]   req_b,
    input  logic    [NUM_REQ-1:0]         req_carry,
    output logic    [NUM_REQ-1:0]         resp_valid,
    input  logic    [NUM_REQ-1:0]         resp_ready,
    output logic    [31:0]                resp_data,
    output logic    [3:0]                 resp_status,
    output logic                          alu_oe,
    output logic    [31:0]                alu_a,
    output logic    [31:0]                alu_b,
    output alu_op_e                       alu_operation,
    output logic                          alu_carry_in,
    input  logic    [31:0]                alu_out,
    input  logic    [3:0]                 alu_status
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state;
    logic [IdxW-1:0]   last_grant;
    logic [IdxW-1:0]   grant;
    logic [IdxW-1:0]   winner;
    logic              found;
    int unsigned       idx;

    // First valid requester after last_grant, wrapping; the last one served ends up last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(last_grant) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IdxW'(idx);
            end
        end
    end

    // Gated by rst_n so no requester sees an accept while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == StIdle && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            last_grant    <= IdxW'(NUM_REQ - 1);
            grant         <= '0;
            alu_operation <= ALU_ADD;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_carry_in  <= 1'b0;
            alu_oe        <= 1'b0;
            resp_data     <= '0;
            resp_status   <= '0;
            resp_valid    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (found) begin
                        alu_operation <= req_op[winner];
                        alu_a         <= req_a[winner];
                        alu_b         <= req_b[winner];
                        alu_carry_in  <= req_carry[winner];
                        grant         <= winner;
                        alu_oe        <= 1'b1;
                        state         <= StExec;
                    end
                end
                StExec: begin
                    resp_data   <= alu_out;
                    resp_status <= alu_status;
                    alu_oe      <= 1'b0;
                    resp_valid  <= NUM_REQ'(1) << grant;
                    state       <= StResp;
                end
                StResp: begin
                    if (resp_ready[grant]) begin
                        last_grant <= grant;
                        resp_valid <= '0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
